lvds_byte_serializer: RTL and testbench
=======================================

# lvds_byte_serializer

Parallel-to-serial transmit stage that produces the single-bit LVDS stream consumed by the team's 8-bit LVDS deserializer. It accepts bytes over a valid/ready handshake into a small FIFO and shifts them out MSB-first, one bit per `lvds_clk`, on a free-running 8-bit frame. When no byte is available at a frame boundary, it inserts a fixed idle byte, so the line never stalls and the receiver's free-running bit counter stays aligned.

## Interface
- `FIFO_DEPTH`, default 4: FIFO entries. Must be a power of 2 and at least 2.
- `IDLE_BYTE`, default 8'hBC: byte transmitted when the FIFO is empty or `i_en` = 0.
- `lvds_clk`, input, 1: bit clock. All logic is on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `i_en`, input, 1: transmit enable. When 0, idle bytes are sent and the FIFO is not popped.
- `i_data`, input, 8: byte to transmit.
- `i_valid`, input, 1: `i_data` is valid.
- `o_ready`, output, 1: FIFO can accept a byte. Equals !full.
- `o_lvds_d`, output, 1: serial data, MSB first.
- `o_frame`, output, 1: high while bit 7 (the MSB) of a byte is on `o_lvds_d`.
- `o_idle_ins`, output, 1: high together with `o_frame` when the current byte is `IDLE_BYTE` inserted by this block.
- `o_level`, output, log2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **Push.** On each rising edge where `i_valid` && `o_ready`, `i_data` is written to the FIFO.
  - `o_ready` is derived from registered occupancy only.
  - When the FIFO is full, no push is accepted, even if a pop occurs on the same edge.
- **Bit counter.** `bit_cnt` is 3 bits, free-running: 0,1,…,7,0. It is not gated by `i_en`.
- **Shift register.** `shift_reg` is 8 bits, and `o_lvds_d` = `shift_reg[7]`.
  - On an edge with `bit_cnt` == 7: `shift_reg` loads the next byte. `bit_cnt` wraps to 0.
  - On any other edge: `shift_reg` <= {`shift_reg[6:0]`, 1'b0}.
- **Next-byte selection.** Evaluated on the `bit_cnt` == 7 edge:
  - If `i_en` && FIFO non-empty: take the FIFO head, pop it, and clear the idle flag.
  - Otherwise: take `IDLE_BYTE`, do not pop, and set the idle flag.
- **Simultaneous push and pop** on a non-full FIFO: both take effect, and `o_level` is unchanged.
  - Push into an empty FIFO on the load edge: the pop sees the pre-edge state (empty), so `IDLE_BYTE` is sent and the pushed byte goes out in the next frame.
- **Pointers.** Read and write pointers wrap modulo `FIFO_DEPTH`.
  - Occupancy is tracked as a counter 0..`FIFO_DEPTH`.
  - Full is `o_level` == `FIFO_DEPTH`; empty is `o_level` == 0.
- **`started` flag.** Set on the first load edge after reset and held.
  - `o_frame` = `started` && (`bit_cnt` == 0).
  - `o_idle_ins` = `o_frame` && idle flag.
- **Bit order.** Bytes are sent MSB first, so a receiver that shifts in at the LSB reconstructs the original byte after 8 bits.

## Timing
- **Reset values:** `shift_reg`=0, `bit_cnt`=0, `started`=0, idle flag=0, FIFO empty.
  - Outputs: `o_lvds_d`=0, `o_frame`=0, `o_idle_ins`=0, `o_level`=0, `o_ready`=1.
- **After reset release:** rising edges 1..7 shift zeros out. Edge 8 is the first load.
  - `o_frame` first goes high in the cycle after edge 8.
  - A byte is then on the line for exactly 8 cycles, MSB in the `o_frame` cycle and LSB 7 cycles later.
- **Latency:** a byte pushed into an empty FIFO on an edge with `bit_cnt` = k (k≠7) appears as an MSB (7−k)+1 cycles after that edge.
- **Throughput:** at most 1 byte per 8 cycles. `o_ready` deasserts on the edge `o_level` reaches `FIFO_DEPTH`.
- **`o_level` timing:** updates on the same edge as the push/pop.
- **`i_en` timing:** sampled only on the load edge. Toggling it mid-byte never truncates a byte.
- **Reset mid-operation:** asynchronously returns everything to reset values. FIFO contents are discarded; a partial byte is truncated.

## Test plan
- **Idle after reset.** Release reset with `i_en`=1 and no pushes.
  - Line is 8 zeros, then repeating 1,0,1,1,1,1,0,0 (8'hBC).
  - `o_frame` and `o_idle_ins` pulse every 8 cycles starting at cycle 9.
- **Single byte.** Push 8'hA5 while `bit_cnt`=2.
  - At the next frame, `o_lvds_d` = 1,0,1,0,0,1,0,1 with `o_frame`=1 on the first bit and `o_idle_ins`=0.
  - `o_level` goes 1 then back to 0 on the load edge.
- **Back-pressure.** Hold `i_valid`=1 with 8'h01,8'h02,… .
  - `o_ready` drops when `o_level`=4.
  - Bytes are sent in order 01,02,03,… with no gaps or duplicates.
  - Exactly one new byte is accepted per 8 cycles thereafter.
- **Push on load edge.** Push 8'h3C on the `bit_cnt`=7 edge into an empty FIFO.
  - `IDLE_BYTE` is sent that frame, and 8'h3C the following frame.
- **Enable gating.** Fill the FIFO with 11,22,33, then set `i_en`=0 for 16 cycles.
  - Two `IDLE_BYTE` frames are sent and `o_level` holds at 3.
  - After `i_en`=1, bytes 11,22,33 follow in order.
- **Reset mid-byte.** Assert `rst_n`=0 at `bit_cnt`=4 with `o_level`=2.
  - All outputs go to reset values immediately.
  - After release, only idle bytes follow, with the first `o_frame` at cycle 9.

Source files
------------

// File: rtl/lvds_byte_serializer.sv
// lvds_byte_serializer: byte FIFO feeding an MSB-first serial line on a free-running 8-bit frame
//   lvds_clk   bit clock, all logic on the rising edge
//   rst_n      asynchronous active-low reset
//   i_en       transmit enable, sampled on the frame load edge only
//   i_data     byte to queue, accepted when i_valid && o_ready
//   i_valid    i_data is valid
//   o_ready    FIFO not full
//   o_lvds_d   serial data, MSB first
//   o_frame    high while a byte's MSB is on o_lvds_d
//   o_idle_ins high with o_frame when the current byte is the inserted idle byte
//   o_level    FIFO occupancy
module lvds_byte_serializer #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] IDLE_BYTE  = 8'hBC
) (
    input  logic                          lvds_clk,
    input  logic                          rst_n,
    input  logic                          i_en,
    input  logic [7:0]                    i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_lvds_d,
    output logic                          o_frame,
    output logic                          o_idle_ins,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   level;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg, next_byte;
    logic          started, idle_flag, push, pop, load;
    assign load       = bit_cnt == 3'd7;
    assign o_ready    = level != (AW+1)'(FIFO_DEPTH);
    assign push       = i_valid && o_ready;
    // the pop decision uses pre-edge occupancy, so a byte pushed on the load edge waits one frame
    assign pop        = load && i_en && level != '0;
    assign next_byte  = pop ? mem[rd_ptr] : IDLE_BYTE;
    assign o_lvds_d   = shift_reg[7];
    assign o_frame    = started && bit_cnt == 3'd0;
    assign o_idle_ins = o_frame && idle_flag;
    assign o_level    = level;
    always_ff @(posedge lvds_clk)
        if (push) mem[wr_ptr] <= i_data;
    always_ff @(posedge lvds_clk or negedge rst_n)
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            started   <= 1'b0;
            idle_flag <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
        end else begin
            bit_cnt   <= bit_cnt + 3'd1;
            shift_reg <= load ? next_byte : {shift_reg[6:0], 1'b0};
            if (load) begin
                started   <= 1'b1;
                idle_flag <= !pop;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
        end
endmodule

// File: tb/tb_lvds_byte_serializer.sv
// tb_lvds_byte_serializer: directed tests for the byte serializer
module tb_lvds_byte_serializer;
    logic       lvds_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_en = 1'b1;
    logic [7:0] i_data = '0;
    logic       i_valid = 1'b0;
    logic       o_ready, o_lvds_d, o_frame, o_idle_ins;
    logic [2:0] o_level;
    int total = 0;
    int bad = 0;

    lvds_byte_serializer dut (
        .lvds_clk(lvds_clk), .rst_n(rst_n), .i_en(i_en), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .o_lvds_d(o_lvds_d), .o_frame(o_frame), .o_idle_ins(o_idle_ins), .o_level(o_level)
    );

    always #5 lvds_clk = ~lvds_clk;

    task automatic tick();
        @(posedge lvds_clk);
        #1;
    endtask

    // Starts on a frame cycle, collects 8 bits, ends on the next frame cycle.
    task automatic get_byte(output logic [7:0] b, output logic idl, output logic fr_ok);
        b = '0;
        idl = o_idle_ins;
        fr_ok = o_frame;
        for (int i = 0; i < 8; i++) begin
            if (i > 0 && (o_frame || o_idle_ins)) fr_ok = 1'b0;
            b = {b[6:0], o_lvds_d};
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        total++; if (o_lvds_d !== 1'b0) begin bad++; $display("FAIL reset_d got=%b exp=0", o_lvds_d); end
        total++; if (o_frame !== 1'b0) begin bad++; $display("FAIL reset_frame got=%b exp=0", o_frame); end
        total++; if (o_idle_ins !== 1'b0) begin bad++; $display("FAIL reset_idle got=%b exp=0", o_idle_ins); end
        total++; if (o_level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", o_level); end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    endtask

    task automatic test_idle();
        logic [7:0] b;
        logic idl, fr_ok;
        rst_n = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            total++; if (o_lvds_d !== 1'b0 || o_frame !== 1'b0) begin bad++; $display("FAIL idle_lead c=%0d d=%b frame=%b exp 0,0", c, o_lvds_d, o_frame); end
        end
        tick();
        total++; if (o_frame !== 1'b1 || o_idle_ins !== 1'b1) begin bad++; $display("FAIL idle_first_frame frame=%b idle=%b exp 1,1", o_frame, o_idle_ins); end
        for (int f = 0; f < 2; f++) begin
            get_byte(b, idl, fr_ok);
            total++; if (b !== 8'hBC || idl !== 1'b1 || fr_ok !== 1'b1) begin bad++; $display("FAIL idle_byte f=%0d got=%h idle=%b frame_ok=%b exp=bc,1,1", f, b, idl, fr_ok); end
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] b;
        logic idl, fr_ok;
        repeat (2) tick();
        i_valid = 1'b1; i_data = 8'hA5;
        tick();
        i_valid = 1'b0;
        total++; if (o_level !== 3'd1) begin bad++; $display("FAIL single_level_push got=%0d exp=1", o_level); end
        repeat (4) tick();
        total++; if (o_level !== 3'd1 || o_frame !== 1'b0) begin bad++; $display("FAIL single_wait level=%0d frame=%b exp 1,0", o_level, o_frame); end
        tick();
        total++; if (o_level !== 3'd0) begin bad++; $display("FAIL single_level_pop got=%0d exp=0", o_level); end
        get_byte(b, idl, fr_ok);
        total++; if (b !== 8'hA5 || idl !== 1'b0 || fr_ok !== 1'b1) begin bad++; $display("FAIL single_byte got=%h idle=%b frame_ok=%b exp=a5,0,1", b, idl, fr_ok); end
    endtask

    task automatic test_push_on_load();
        logic [7:0] b;
        logic idl, fr_ok;
        repeat (7) tick();
        i_valid = 1'b1; i_data = 8'h3C;
        tick();
        i_valid = 1'b0;
        total++; if (o_level !== 3'd1) begin bad++; $display("FAIL pol_level got=%0d exp=1", o_level); end
        get_byte(b, idl, fr_ok);
        total++; if (b !== 8'hBC || idl !== 1'b1) begin bad++; $display("FAIL pol_idle got=%h idle=%b exp=bc,1", b, idl); end
        get_byte(b, idl, fr_ok);
        total++; if (b !== 8'h3C || idl !== 1'b0 || fr_ok !== 1'b1) begin bad++; $display("FAIL pol_data got=%h idle=%b frame_ok=%b exp=3c,0,1", b, idl, fr_ok); end
    endtask

    task automatic test_back_pressure();
        logic [7:0] rx, nxt, exp_rx, b;
        logic fi, took, idl, fr_ok;
        int acc, data_frames, idle_frames;
        rx = '0; nxt = 8'd1; exp_rx = 8'd1; fi = 1'b0;
        acc = 0; data_frames = 0; idle_frames = 0;
        i_valid = 1'b1; i_data = nxt;
        for (int c = 0; c < 64; c++) begin
            if (c == 4) begin
                total++; if (o_level !== 3'd4 || o_ready !== 1'b0) begin bad++; $display("FAIL bp_full level=%0d ready=%b exp 4,0", o_level, o_ready); end
            end
            if (c == 8) begin
                total++; if (o_level !== 3'd3 || o_ready !== 1'b1) begin bad++; $display("FAIL bp_after_pop level=%0d ready=%b exp 3,1", o_level, o_ready); end
            end
            if (c == 9) begin
                total++; if (o_level !== 3'd4 || o_ready !== 1'b0) begin bad++; $display("FAIL bp_refill level=%0d ready=%b exp 4,0", o_level, o_ready); end
            end
            if (c % 8 == 0) fi = o_idle_ins;
            rx = {rx[6:0], o_lvds_d};
            if (c % 8 == 7) begin
                if (fi) idle_frames++;
                else begin
                    total++; if (rx !== exp_rx) begin bad++; $display("FAIL bp_order got=%h exp=%h", rx, exp_rx); end
                    exp_rx++;
                    data_frames++;
                end
            end
            took = i_valid && o_ready;
            if (took) acc++;
            tick();
            if (took) begin nxt++; i_data = nxt; end
        end
        i_valid = 1'b0;
        total++; if (acc != 11) begin bad++; $display("FAIL bp_accepts got=%0d exp=11", acc); end
        total++; if (data_frames != 7 || idle_frames != 1) begin bad++; $display("FAIL bp_frames data=%0d idle=%0d exp 7,1", data_frames, idle_frames); end
        total++; if (o_level !== 3'd3) begin bad++; $display("FAIL bp_level_end got=%0d exp=3", o_level); end
        for (int k = 0; k < 4; k++) begin
            get_byte(b, idl, fr_ok);
            total++; if (b !== exp_rx || idl !== 1'b0 || fr_ok !== 1'b1) begin bad++; $display("FAIL bp_drain got=%h idle=%b frame_ok=%b exp=%h,0,1", b, idl, fr_ok, exp_rx); end
            exp_rx++;
        end
        total++; if (o_level !== 3'd0) begin bad++; $display("FAIL bp_drained got=%0d exp=0", o_level); end
    endtask

    task automatic test_enable_gating();
        logic [7:0] b;
        logic [7:0] exp_b [3];
        logic idl, fr_ok;
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1; i_data = exp_b[k];
            tick();
        end
        i_valid = 1'b0;
        i_en = 1'b0;
        repeat (5) tick();
        get_byte(b, idl, fr_ok);
        total++; if (b !== 8'hBC || idl !== 1'b1 || o_level !== 3'd3) begin bad++; $display("FAIL en_idle1 got=%h idle=%b level=%0d exp=bc,1,3", b, idl, o_level); end
        i_en = 1'b1;
        get_byte(b, idl, fr_ok);
        total++; if (b !== 8'hBC || idl !== 1'b1) begin bad++; $display("FAIL en_idle2 got=%h idle=%b exp=bc,1", b, idl); end
        for (int k = 0; k < 3; k++) begin
            get_byte(b, idl, fr_ok);
            total++; if (b !== exp_b[k] || idl !== 1'b0) begin bad++; $display("FAIL en_data k=%0d got=%h idle=%b exp=%h,0", k, b, idl, exp_b[k]); end
        end
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] b;
        logic idl, fr_ok;
        i_valid = 1'b1; i_data = 8'h5A; tick();
        i_data = 8'h66; tick();
        i_valid = 1'b0;
        repeat (2) tick();
        total++; if (o_level !== 3'd2 || o_lvds_d !== 1'b1) begin bad++; $display("FAIL rst_pre level=%0d d=%b exp 2,1", o_level, o_lvds_d); end
        rst_n = 1'b0;
        #1;
        total++; if (o_lvds_d !== 1'b0 || o_frame !== 1'b0 || o_idle_ins !== 1'b0) begin bad++; $display("FAIL rst_async d=%b frame=%b idle=%b exp 0,0,0", o_lvds_d, o_frame, o_idle_ins); end
        total++; if (o_level !== 3'd0 || o_ready !== 1'b1) begin bad++; $display("FAIL rst_async_fifo level=%0d ready=%b exp 0,1", o_level, o_ready); end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            total++; if (o_lvds_d !== 1'b0 || o_frame !== 1'b0) begin bad++; $display("FAIL rst_lead c=%0d d=%b frame=%b exp 0,0", c, o_lvds_d, o_frame); end
        end
        tick();
        for (int f = 0; f < 2; f++) begin
            get_byte(b, idl, fr_ok);
            total++; if (b !== 8'hBC || idl !== 1'b1 || fr_ok !== 1'b1) begin bad++; $display("FAIL rst_idle f=%0d got=%h idle=%b frame_ok=%b exp=bc,1,1", f, b, idl, fr_ok); end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_byte();
        test_push_on_load();
        test_back_pressure();
        test_enable_gating();
        test_reset_mid_byte();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
